// File: rtl/aes_loader_pkg.sv
// -----------------------------------------------------------------------------
// aes_loader_pkg
// Shared types and constants for the AES stream loader: the loader FSM state
// encoding, word/block geometry, and a helper that picks one 32-bit word out
// of a 128-bit block (word 0 is the most significant word).
// -----------------------------------------------------------------------------
package aes_loader_pkg;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int IDX_W           = 2;

  // Index of the final word in a block; counters wrap to 0 after it.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Word 0 is bits [127:96], word 3 is bits [31:0].
  function automatic logic [WORD_W-1:0] word_select(
    input logic [BLOCK_W-1:0] blk,
    input logic [IDX_W-1:0]   idx
  );
    logic [WORD_W-1:0] w;
    unique case (idx)
      2'd0: w = blk[4*WORD_W-1 -: WORD_W];
      2'd1: w = blk[3*WORD_W-1 -: WORD_W];
      2'd2: w = blk[2*WORD_W-1 -: WORD_W];
      2'd3: w = blk[1*WORD_W-1 -: WORD_W];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes_word_packer.sv
// -----------------------------------------------------------------------------
// aes_word_packer
// Assembles four 32-bit words into a 128-bit register. Each accepted word is
// written in place at the slot selected by a 2-bit counter (first word to
// [127:96]) and the counter wraps mod 4, so older slots are kept until
// overwritten.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous active-high reset (register and counter)
//   load_en    in   1    accept word_in this cycle
//   word_in    in   32   word to store
//   block_out  out  128  assembled block
//   last_word  out  1    load_en while the counter points at the final slot
// -----------------------------------------------------------------------------
module aes_word_packer
  import aes_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [WORD_W-1:0]  word_in,
  output logic [BLOCK_W-1:0] block_out,
  output logic               last_word
);

  logic [BLOCK_W-1:0] block_q, block_d;
  logic [IDX_W-1:0]   count_q, count_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    block_d = block_q;
    count_d = count_q;
    if (load_en) begin
      unique case (count_q)
        2'd0: block_d[4*WORD_W-1 -: WORD_W] = word_in;
        2'd1: block_d[3*WORD_W-1 -: WORD_W] = word_in;
        2'd2: block_d[2*WORD_W-1 -: WORD_W] = word_in;
        2'd3: block_d[1*WORD_W-1 -: WORD_W] = word_in;
      endcase
      count_d = count_q + 2'd1;
    end
  end

  assign last_word = load_en && (count_q == LAST_IDX);
  assign block_out = block_q;

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (rst) begin
      // NOTE: this is a flop register, not a RAM; it is reset because the
      // engine inputs must read as zero after reset.
      block_q <= '0;
      count_q <= '0;
    end else begin
      block_q <= block_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/aes_stream_loader.sv
// -----------------------------------------------------------------------------
// aes_stream_loader
// Feeds the AES engine from a 32-bit word stream and returns the result as a
// 32-bit valid/ready stream. One block in flight at a time:
//   LOAD  - accept key/data words; the 4th data word launches the engine
//   RUN   - AES_en held high with stable key/data until AES_data_out_valid
//   DRAIN - four result words out, most significant word first
//
// Optional build macro: AES_LOADER_TIMEOUT_EN enables a RUN watchdog of
// TIMEOUT_CYCLES cycles that aborts back to LOAD and sets sticky timeout_err.
// Without it RUN waits indefinitely and timeout_err is tied to 0.
//
// Ports:
//   AES_clk, AES_rst            clock, synchronous active-high reset
//   in_valid/in_ready/in_data   input word stream, in_is_key selects key path
//   out_valid/out_ready/out_data result word stream
//   busy                        block launched and not yet fully drained
//   timeout_err                 sticky watchdog flag
//   AES_en, AES_data_in, AES_key_in        engine launch interface
//   AES_data_out, AES_data_out_valid       engine result interface
// -----------------------------------------------------------------------------
module aes_stream_loader
  import aes_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               AES_clk,
  input  logic               AES_rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_is_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic               busy,
  output logic               timeout_err,
  output logic               AES_en,
  output logic [BLOCK_W-1:0] AES_data_in,
  output logic [BLOCK_W-1:0] AES_key_in,
  input  logic [BLOCK_W-1:0] AES_data_out,
  input  logic               AES_data_out_valid
);

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] result_q, result_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;

  logic in_fire;
  logic key_load;
  logic data_load;
  logic data_last;
  logic key_group_done_unused;
  logic timeout_hit;

  // A limit below one cycle cannot describe a watchdog; the named block makes
  // such an override visible in the elaborated hierarchy.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cfg_invalid
  end

  // Input acceptance depends only on the registered state, which keeps the
  // handshake free of combinational loops through the packers.
  assign in_fire   = in_valid && (state_q == LOAD);
  assign key_load  = in_fire && in_is_key;
  assign data_load = in_fire && !in_is_key;

  // Key groups never launch a block; the key is simply rewritten in place.
  aes_word_packer u_key_packer (
    .clk       (AES_clk),
    .rst       (AES_rst),
    .load_en   (key_load),
    .word_in   (in_data),
    .block_out (AES_key_in),
    .last_word (key_group_done_unused)
  );

  aes_word_packer u_data_packer (
    .clk       (AES_clk),
    .rst       (AES_rst),
    .load_en   (data_load),
    .word_in   (in_data),
    .block_out (AES_data_in),
    .last_word (data_last)
  );

  // Next-state logic. The valid branch is tested before the watchdog so a
  // result arriving on the timeout cycle is still delivered.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    out_idx_d = out_idx_q;
    unique case (state_q)
      LOAD: begin
        if (data_last) state_d = RUN;
      end
      RUN: begin
        if (AES_data_out_valid) begin
          result_d = AES_data_out;
          state_d  = DRAIN;
        end else if (timeout_hit) begin
          state_d = LOAD;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          out_idx_d = out_idx_q + 2'd1;
          if (out_idx_q == LAST_IDX) state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    in_ready  = 1'b0;
    AES_en    = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = (state_q != LOAD);
    unique case (state_q)
      LOAD:  in_ready = 1'b1;
      RUN:   AES_en   = 1'b1;
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = word_select(result_q, out_idx_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state_q   <= LOAD;
      result_q  <= '0;
      out_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      out_idx_q <= out_idx_d;
    end
  end

`ifdef AES_LOADER_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  // The timer reads 0 on the first RUN cycle, so hitting LIMIT-1 means the
  // engine has had exactly TIMEOUT_CYCLES cycles of AES_en.
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               timeout_err_q, timeout_err_d;

  always_comb begin
    timer_d       = '0;
    timeout_err_d = timeout_err_q;
    if (state_q == RUN) begin
      timer_d = timer_q + TIMER_W'(1);
      if (timeout_hit && !AES_data_out_valid) timeout_err_d = 1'b1;
    end
  end

  assign timeout_hit = (state_q == RUN) && (timer_q == TIMER_LAST);
  assign timeout_err = timeout_err_q;

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_aes_stream_loader
// Self-checking bench for aes_stream_loader. A table of key/data words with
// their expected packed registers opens the test, followed by hand sequences
// for engine capture, drain back-pressure, reset during RUN and ignored engine
// strobes, then randomized blocks checked against a word-array model.
// Define AES_LOADER_TIMEOUT_EN to also exercise the watchdog (limit 20).
// -----------------------------------------------------------------------------
module tb_aes_stream_loader;

  localparam int TMO = 20;

  logic         AES_clk = 1'b0;
  logic         AES_rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_is_key = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic         busy;
  logic         timeout_err;
  logic         AES_en;
  logic [127:0] AES_data_in;
  logic [127:0] AES_key_in;
  logic [127:0] AES_data_out = '0;
  logic         AES_data_out_valid = 1'b0;

  always #5 AES_clk = ~AES_clk;

  aes_stream_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .AES_clk            (AES_clk),
    .AES_rst            (AES_rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .in_is_key          (in_is_key),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_data           (out_data),
    .busy               (busy),
    .timeout_err        (timeout_err),
    .AES_en             (AES_en),
    .AES_data_in        (AES_data_in),
    .AES_key_in         (AES_key_in),
    .AES_data_out       (AES_data_out),
    .AES_data_out_valid (AES_data_out_valid)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: cycle budget expired", name);
  endtask

  // Reference model: the words most recently written to each slot, and the
  // slot the next word of each kind will land in.
  logic [31:0] m_key[4];
  logic [31:0] m_data[4];
  int          m_kidx;
  int          m_didx;
  logic        launched;

  function automatic logic [127:0] pack4(input logic [31:0] w[4]);
    return {w[0], w[1], w[2], w[3]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_key[i]  = '0;
      m_data[i] = '0;
    end
    m_kidx = 0;
    m_didx = 0;
  endtask

  task automatic tick();
    @(posedge AES_clk);
    #1;
  endtask

  task automatic send_word(input logic is_key, input logic [31:0] w);
    check1("load_in_ready", in_ready, 1'b1);
    in_valid  = 1'b1;
    in_is_key = is_key;
    in_data   = w;
    tick();
    in_valid = 1'b0;
    if (is_key) begin
      m_key[m_kidx] = w;
      m_kidx = (m_kidx + 1) % 4;
    end else begin
      m_data[m_didx] = w;
      m_didx = (m_didx + 1) % 4;
    end
    launched = !is_key && (m_didx == 0);
    check128("pack_key", AES_key_in, pack4(m_key));
    check128("pack_data", AES_data_in, pack4(m_data));
    check1("launch_en", AES_en, launched);
    check1("launch_busy", busy, launched);
  endtask

  // Engine stub: holds off for `latency` RUN cycles (with junk on the input
  // stream), then presents the result for one cycle.
  task automatic engine(input int latency, input logic [127:0] res);
    for (int c = 0; c < latency; c++) begin
      check1("run_en", AES_en, 1'b1);
      check1("run_in_ready", in_ready, 1'b0);
      check1("run_busy", busy, 1'b1);
      check128("run_key_stable", AES_key_in, pack4(m_key));
      check128("run_data_stable", AES_data_in, pack4(m_data));
      in_valid     = 1'($urandom_range(0, 1));
      in_is_key    = 1'($urandom_range(0, 1));
      in_data      = $urandom;
      AES_data_out = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
    check1("run_en_last", AES_en, 1'b1);
    AES_data_out       = res;
    AES_data_out_valid = 1'b1;
    tick();
    AES_data_out_valid = 1'b0;
    AES_data_out       = ~res;
    check1("cap_out_valid", out_valid, 1'b1);
    check1("cap_en_low", AES_en, 1'b0);
  endtask

  // Drain four words; out_ready is low for `hold` cycles or random when rnd.
  task automatic drain(input logic [127:0] res, input int hold, input logic rnd);
    logic [31:0] exp_w[4];
    int idx = 0;
    int cyc = 0;
    for (int i = 0; i < 4; i++) exp_w[i] = res[127 - 32*i -: 32];
    while (idx < 4 && cyc < 100) begin
      check1("drain_valid", out_valid, 1'b1);
      check32("drain_word", out_data, exp_w[idx]);
      check1("drain_in_ready", in_ready, 1'b0);
      out_ready          = rnd ? 1'($urandom_range(0, 1)) : (cyc >= hold);
      in_valid           = 1'($urandom_range(0, 1));
      in_data            = $urandom;
      AES_data_out_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      AES_data_out       = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (out_ready) idx++;
      cyc++;
    end
    out_ready          = 1'b0;
    in_valid           = 1'b0;
    AES_data_out_valid = 1'b0;
    if (idx < 4) bound_fail("drain_budget");
    check1("drain_done_valid", out_valid, 1'b0);
    check1("drain_done_in_ready", in_ready, 1'b1);
    check1("drain_done_busy", busy, 1'b0);
    check128("drain_key_kept", AES_key_in, pack4(m_key));
    check128("drain_data_kept", AES_data_in, pack4(m_data));
  endtask

  typedef struct {
    logic         is_key;
    logic [31:0]  word;
    logic [127:0] exp_key;
    logic [127:0] exp_data;
    logic         exp_busy;
  } vec_t;

  localparam logic [127:0] KEY1 = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
  localparam logic [127:0] DAT1 = 128'h0000007c_00000000_00000000_00000000;
  localparam logic [127:0] RES1 = 128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [127:0] DAT2 = 128'ha6f2daeb_140fa720_529e75d5_21cbc681;
  localparam logic [127:0] RES2 = 128'h3925841d_02dc09fb_dc118597_196a0b32;

  vec_t tbl[8];

  initial begin
    logic [127:0] r;
    logic [31:0]  dw[4];
    int           guard;
    int           cnt;

    tbl[0] = '{1'b1, 32'haa2bdb40, 128'haa2bdb40_00000000_00000000_00000000, 128'h0, 1'b0};
    tbl[1] = '{1'b1, 32'hbff6a5e8, 128'haa2bdb40_bff6a5e8_00000000_00000000, 128'h0, 1'b0};
    tbl[2] = '{1'b1, 32'hcaa9ba3e, 128'haa2bdb40_bff6a5e8_caa9ba3e_00000000, 128'h0, 1'b0};
    tbl[3] = '{1'b1, 32'hbc1e2acc, KEY1, 128'h0, 1'b0};
    tbl[4] = '{1'b0, 32'h0000007c, KEY1, DAT1, 1'b0};
    tbl[5] = '{1'b0, 32'h00000000, KEY1, DAT1, 1'b0};
    tbl[6] = '{1'b0, 32'h00000000, KEY1, DAT1, 1'b0};
    tbl[7] = '{1'b0, 32'h00000000, KEY1, DAT1, 1'b1};

    // Reset values.
    model_reset();
    AES_rst = 1'b1;
    tick();
    tick();
    AES_rst = 1'b0;
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_out_valid", out_valid, 1'b0);
    check32("rst_out_data", out_data, 32'h0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_timeout_err", timeout_err, 1'b0);
    check1("rst_en", AES_en, 1'b0);
    check128("rst_key", AES_key_in, 128'h0);
    check128("rst_data", AES_data_in, 128'h0);

    // Table: first block's key and data words.
    for (int i = 0; i < 8; i++) begin
      send_word(tbl[i].is_key, tbl[i].word);
      check128("tbl_key", AES_key_in, tbl[i].exp_key);
      check128("tbl_data", AES_data_in, tbl[i].exp_data);
      check1("tbl_busy", busy, tbl[i].exp_busy);
      check1("tbl_en", AES_en, tbl[i].exp_busy);
    end
    engine(12, RES1);
    drain(RES1, 0, 1'b0);

    // Second block reuses the key; drain with three cycles of back-pressure.
    for (int i = 0; i < 4; i++) send_word(1'b0, DAT2[127 - 32*i -: 32]);
    check128("blk2_key_kept", AES_key_in, KEY1);
    check128("blk2_data", AES_data_in, DAT2);
    engine(3, RES2);
    drain(RES2, 3, 1'b0);

    // Engine strobe while idle is ignored.
    AES_data_out       = RES1;
    AES_data_out_valid = 1'b1;
    tick();
    AES_data_out_valid = 1'b0;
    check1("idle_strobe_valid", out_valid, 1'b0);
    check1("idle_strobe_busy", busy, 1'b0);
    check1("idle_strobe_in_ready", in_ready, 1'b1);

    // Reset during RUN with a partial key group outstanding.
    send_word(1'b1, 32'h0badf00d);
    send_word(1'b1, 32'h12345678);
    for (int i = 0; i < 4; i++) send_word(1'b0, $urandom);
    tick();
    tick();
    check1("pre_rst_en", AES_en, 1'b1);
    AES_rst = 1'b1;
    tick();
    AES_rst = 1'b0;
    model_reset();
    check1("run_rst_en", AES_en, 1'b0);
    check1("run_rst_busy", busy, 1'b0);
    check1("run_rst_in_ready", in_ready, 1'b1);
    check1("run_rst_out_valid", out_valid, 1'b0);
    check128("run_rst_key", AES_key_in, 128'h0);
    check128("run_rst_data", AES_data_in, 128'h0);
    send_word(1'b1, 32'hcafef00d);
    check128("rst_key_cnt", AES_key_in, 128'hcafef00d_00000000_00000000_00000000);
    send_word(1'b0, 32'h5a5a5a5a);
    check128("rst_data_cnt", AES_data_in, 128'h5a5a5a5a_00000000_00000000_00000000);

    // Randomized blocks against the model.
    for (int b = 0; b < 30; b++) begin
      launched = 1'b0;
      guard    = 0;
      while (!launched && guard < 200) begin
        guard++;
        if ($urandom_range(0, 3) == 0) begin
          in_valid           = 1'b0;
          in_data            = $urandom;
          AES_data_out_valid = 1'($urandom_range(0, 1));
          AES_data_out       = {$urandom, $urandom, $urandom, $urandom};
          tick();
          AES_data_out_valid = 1'b0;
          check1("rnd_idle_busy", busy, 1'b0);
          check1("rnd_idle_out_valid", out_valid, 1'b0);
          check128("rnd_idle_key", AES_key_in, pack4(m_key));
          check128("rnd_idle_data", AES_data_in, pack4(m_data));
        end else begin
          send_word(($urandom_range(0, 2) == 0), $urandom);
        end
      end
      if (!launched) begin
        bound_fail("rnd_launch_budget");
        break;
      end
      for (int i = 0; i < 4; i++) dw[i] = $urandom;
      r = {dw[0], dw[1], dw[2], dw[3]};
      engine($urandom_range(0, 10), r);
      drain(r, 0, 1'b1);
    end

`ifdef AES_LOADER_TIMEOUT_EN
    // Watchdog: the engine never answers.
    for (int i = 0; i < 4; i++) send_word(1'b0, $urandom);
    cnt = 0;
    while (AES_en && cnt < 100) begin
      cnt++;
      tick();
    end
    check32("tmo_run_cycles", 32'(cnt), 32'(TMO));
    check1("tmo_err", timeout_err, 1'b1);
    check1("tmo_in_ready", in_ready, 1'b1);
    check1("tmo_busy", busy, 1'b0);
    check1("tmo_out_valid", out_valid, 1'b0);
    tick();
    tick();
    check1("tmo_err_sticky", timeout_err, 1'b1);
`else
    cnt = 0;
    check1("tmo_disabled", timeout_err, 1'b0);
    check32("tmo_cnt_unused", 32'(cnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
